// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: widths, FSM
// encodings, RISC-V opcodes and immediate field extraction helpers.
package instruction_fetch_unit_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 32;
    localparam int INST_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // J-immediate from inst[31:12]; result is the signed byte offset.
    function automatic logic signed [20:0] imm_j(input logic [19:0] f);
        return {f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

    // B-immediate from inst[31:25] (hi) and inst[11:7] (lo).
    function automatic logic signed [12:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
        return {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_inst_queue.sv
// DEPTH-entry synchronous FIFO holding {pc, pred_pc, inst}; the head is read
// straight from the storage array so a pushed entry is visible next cycle.
module inst_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [ADDR_WIDTH-1:0]    push_pc,
    input  logic [ADDR_WIDTH-1:0]    push_pred_pc,
    input  logic [INST_WIDTH-1:0]    push_inst,
    output logic [ADDR_WIDTH-1:0]    head_pc,
    output logic [ADDR_WIDTH-1:0]    head_pred_pc,
    output logic [INST_WIDTH-1:0]    head_inst,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] pred_mem [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push & ~clear & (~full | pop);
    assign do_pop  = pop & ~clear & ~empty;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            pc_mem[wr_ptr_reg]   <= push_pc;
            pred_mem[wr_ptr_reg] <= push_pred_pc;
            inst_mem[wr_ptr_reg] <= push_inst;
        end
    end

    assign head_pc      = pc_mem[rd_ptr_reg];
    assign head_pred_pc = pred_mem[rd_ptr_reg];
    assign head_inst    = inst_mem[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, one-outstanding fetch FSM and instruction queue.
// Define FETCH_STATIC_PREDICT_EN to predict JAL and backward branches as taken.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int INST_WIDTH = INST_WIDTH_DEFAULT,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  if_to_mc_valid,
    output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
    input  logic                  mc_to_if_done,
    input  logic [INST_WIDTH-1:0] mc_to_if_inst,
    output logic                  if_to_dc_valid,
    input  logic                  dc_to_if_ready,
    output logic [INST_WIDTH-1:0] if_to_dc_inst,
    output logic [ADDR_WIDTH-1:0] if_to_dc_pc,
    output logic [ADDR_WIDTH-1:0] if_to_dc_pred_pc,
    input  logic                  rob_to_if_flush,
    input  logic [ADDR_WIDTH-1:0] rob_to_if_target
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
    logic                  req_valid_reg, req_valid_next;
    logic [ADDR_WIDTH-1:0] pred_pc;

    logic             q_push, q_pop, q_clear, q_full, q_empty;
    logic [CNT_W-1:0] q_count, count_after;
    logic             flush_act, done_wait, room_after;

    assign flush_act   = rdy_in & rob_to_if_flush;
    assign done_wait   = (state_reg == FETCH_WAIT) & mc_to_if_done;
    assign q_clear     = flush_act;
    assign q_push      = rdy_in & done_wait & ~rob_to_if_flush;
    assign q_pop       = rdy_in & if_to_dc_valid & dc_to_if_ready;
    // Occupancy after this cycle's enqueue and any simultaneous dequeue.
    assign count_after = q_count + CNT_W'(done_wait) - CNT_W'(q_pop);
    assign room_after  = (count_after < DEPTH_C);

    always_comb begin
        pred_pc = pc_reg + ADDR_WIDTH'(4);
`ifdef FETCH_STATIC_PREDICT_EN
        if (mc_to_if_inst[6:0] == OPC_JAL) begin
            pred_pc = pc_reg + ADDR_WIDTH'(imm_j(mc_to_if_inst[31:12]));
        end else if (mc_to_if_inst[6:0] == OPC_BRANCH && mc_to_if_inst[31]) begin
            pred_pc = pc_reg + ADDR_WIDTH'(imm_b(mc_to_if_inst[31:25], mc_to_if_inst[11:7]));
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= FETCH_IDLE;
            pc_reg        <= RESET_PC;
            req_valid_reg <= 1'b0;
            req_addr_reg  <= '0;
        end else if (rdy_in) begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            req_valid_reg <= req_valid_next;
            req_addr_reg  <= req_addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH_IDLE: begin
                if (!rob_to_if_flush && !q_full) state_next = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mc_to_if_done) begin
                    state_next = (rob_to_if_flush || !room_after) ? FETCH_IDLE : FETCH_WAIT;
                end else if (rob_to_if_flush) begin
                    state_next = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (mc_to_if_done) state_next = FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    // A discarded request keeps valid/addr asserted until memory answers it.
    always_comb begin
        pc_next        = rob_to_if_flush ? rob_to_if_target : pc_reg;
        req_valid_next = req_valid_reg;
        req_addr_next  = req_addr_reg;
        case (state_reg)
            FETCH_IDLE: begin
                if (!rob_to_if_flush && !q_full) begin
                    req_valid_next = 1'b1;
                    req_addr_next  = pc_reg;
                end
            end
            FETCH_WAIT: begin
                if (mc_to_if_done) begin
                    if (rob_to_if_flush) begin
                        req_valid_next = 1'b0;
                    end else begin
                        pc_next = pred_pc;
                        if (room_after) req_addr_next = pred_pc;
                        else            req_valid_next = 1'b0;
                    end
                end
            end
            FETCH_DISCARD: begin
                if (mc_to_if_done) req_valid_next = 1'b0;
            end
            default: req_valid_next = 1'b0;
        endcase
    end

    assign if_to_mc_valid = req_valid_reg;
    assign if_to_mc_addr  = req_addr_reg;
    assign if_to_dc_valid = ~q_empty & ~flush_act;

    inst_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_inst_queue (
        .clk          (clk_in),
        .srst         (rst_in),
        .push         (q_push),
        .pop          (q_pop),
        .clear        (q_clear),
        .push_pc      (pc_reg),
        .push_pred_pc (pred_pc),
        .push_inst    (mc_to_if_inst),
        .head_pc      (if_to_dc_pc),
        .head_pred_pc (if_to_dc_pred_pc),
        .head_inst    (if_to_dc_inst),
        .full         (q_full),
        .empty        (q_empty),
        .count        (q_count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, queue-full backpressure,
// flush cases, rdy_in stall, reset mid-request and (optional) static prediction.
module tb_instruction_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_to_mc_valid;
    logic [31:0] if_to_mc_addr;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_inst;
    logic        if_to_dc_valid;
    logic        dc_to_if_ready;
    logic [31:0] if_to_dc_inst;
    logic [31:0] if_to_dc_pc;
    logic [31:0] if_to_dc_pred_pc;
    logic        rob_to_if_flush;
    logic [31:0] rob_to_if_target;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_unit dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .if_to_mc_valid   (if_to_mc_valid),
        .if_to_mc_addr    (if_to_mc_addr),
        .mc_to_if_done    (mc_to_if_done),
        .mc_to_if_inst    (mc_to_if_inst),
        .if_to_dc_valid   (if_to_dc_valid),
        .dc_to_if_ready   (dc_to_if_ready),
        .if_to_dc_inst    (if_to_dc_inst),
        .if_to_dc_pc      (if_to_dc_pc),
        .if_to_dc_pred_pc (if_to_dc_pred_pc),
        .rob_to_if_flush  (rob_to_if_flush),
        .rob_to_if_target (rob_to_if_target)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        #1;
        if (rdy_in && !rst_in && if_to_dc_valid && dc_to_if_ready)
            $display("deq pc=%h inst=%h pred=%h", if_to_dc_pc, if_to_dc_inst, if_to_dc_pred_pc);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1; mc_to_if_done = 1'b0; mc_to_if_inst = '0;
        dc_to_if_ready = 1'b0; rob_to_if_flush = 1'b0; rob_to_if_target = '0;
        step(); step();
        chk("rst_mc_valid", 32'(if_to_mc_valid), 32'd0);
        chk("rst_mc_addr", if_to_mc_addr, 32'h0);
        chk("rst_dc_valid", 32'(if_to_dc_valid), 32'd0);
        rst_in = 1'b0;
        step();
    endtask

    // Flush coinciding with done from WAIT, then land in WAIT at the target.
    task automatic redirect(input logic [31:0] target);
        rob_to_if_flush = 1'b1; rob_to_if_target = target; mc_to_if_done = 1'b1;
        step();
        rob_to_if_flush = 1'b0; mc_to_if_done = 1'b0;
        step();
        chk("redir_addr", if_to_mc_addr, target);
    endtask

    task automatic predict_case(input logic [31:0] at, input logic [31:0] inst,
                                input logic [31:0] exp_next);
        redirect(at);
        mc_to_if_done = 1'b1; mc_to_if_inst = inst;
        step();
        mc_to_if_done = 1'b0;
        chk("pred_pc", if_to_dc_pred_pc, exp_next);
        chk("pred_next_addr", if_to_mc_addr, exp_next);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with decoder always ready.
        do_reset();
        dc_to_if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("stream_mc_valid", 32'(if_to_mc_valid), 32'd1);
            chk("stream_addr", if_to_mc_addr, 32'(4 * k));
            mc_to_if_done = 1'b0;
            step();
            mc_to_if_done = 1'b1; mc_to_if_inst = 32'h13 | 32'(k << 7);
            step();
            mc_to_if_done = 1'b0;
            chk("stream_dc_valid", 32'(if_to_dc_valid), 32'd1);
            chk("stream_dc_pc", if_to_dc_pc, 32'(4 * k));
            chk("stream_dc_inst", if_to_dc_inst, 32'h13 | 32'(k << 7));
            chk("stream_dc_pred", if_to_dc_pred_pc, 32'(4 * k + 4));
        end

        // Queue fills with decoder stalled, then one dequeue reopens fetch.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            chk("fill_addr", if_to_mc_addr, 32'(4 * k));
            mc_to_if_done = 1'b1; mc_to_if_inst = 32'h100 + 32'(k);
            step();
        end
        chk("full_mc_valid", 32'(if_to_mc_valid), 32'd0);
        chk("full_dc_pc", if_to_dc_pc, 32'h0);
        chk("full_dc_inst", if_to_dc_inst, 32'h100);
        step();
        chk("full_idle_done_ignored", 32'(if_to_mc_valid), 32'd0);
        mc_to_if_done = 1'b0; dc_to_if_ready = 1'b1;
        step();
        dc_to_if_ready = 1'b0;
        chk("pop_no_req_same_cycle", 32'(if_to_mc_valid), 32'd0);
        chk("pop_dc_pc", if_to_dc_pc, 32'h4);
        step();
        chk("reopen_mc_valid", 32'(if_to_mc_valid), 32'd1);
        chk("reopen_addr", if_to_mc_addr, 32'h10);

        // Flush while a request is pending; its data arrives three cycles later.
        rob_to_if_flush = 1'b1; rob_to_if_target = 32'h100;
        #1;
        chk("flush_dc_valid_forced", 32'(if_to_dc_valid), 32'd0);
        step();
        rob_to_if_flush = 1'b0;
        chk("discard_dc_valid", 32'(if_to_dc_valid), 32'd0);
        chk("discard_mc_addr", if_to_mc_addr, 32'h10);
        step(); step();
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'hdeadbeef;
        step();
        mc_to_if_done = 1'b0;
        chk("discard_dropped", 32'(if_to_dc_valid), 32'd0);
        chk("discard_idle", 32'(if_to_mc_valid), 32'd0);
        step();
        chk("flush_req_valid", 32'(if_to_mc_valid), 32'd1);
        chk("flush_req_addr", if_to_mc_addr, 32'h100);

        // Flush with simultaneous done while two entries are queued.
        mc_to_if_done = 1'b1; mc_to_if_inst = 32'h13;
        step(); step();
        chk("two_entries_head", if_to_dc_pc, 32'h100);
        chk("two_entries_addr", if_to_mc_addr, 32'h108);
        rob_to_if_flush = 1'b1; rob_to_if_target = 32'h200; dc_to_if_ready = 1'b1;
        #1;
        chk("flushdone_dc_valid", 32'(if_to_dc_valid), 32'd0);
        step();
        rob_to_if_flush = 1'b0; mc_to_if_done = 1'b0; dc_to_if_ready = 1'b0;
        chk("flushdone_empty", 32'(if_to_dc_valid), 32'd0);
        chk("flushdone_idle", 32'(if_to_mc_valid), 32'd0);
        step();
        chk("flushdone_req_addr", if_to_mc_addr, 32'h200);

        // rdy_in low freezes everything even with done pulsing.
        rdy_in = 1'b0; mc_to_if_done = 1'b1; mc_to_if_inst = 32'h13;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frozen_addr", if_to_mc_addr, 32'h200);
            chk("frozen_dc_valid", 32'(if_to_dc_valid), 32'd0);
        end
        rdy_in = 1'b1; mc_to_if_done = 1'b0;
        step();
        chk("resume_addr", if_to_mc_addr, 32'h200);
        mc_to_if_done = 1'b1;
        step();
        mc_to_if_done = 1'b0;
        chk("resume_dc_pc", if_to_dc_pc, 32'h200);
        chk("resume_next_addr", if_to_mc_addr, 32'h204);

        // Reset mid-request, stray done right after is ignored.
        rst_in = 1'b1;
        step();
        rst_in = 1'b0; mc_to_if_done = 1'b1;
        step();
        chk("stray_dc_valid", 32'(if_to_dc_valid), 32'd0);
        chk("stray_mc_addr", if_to_mc_addr, 32'h0);
        step();
        mc_to_if_done = 1'b0;
        chk("after_rst_dc_pc", if_to_dc_pc, 32'h0);

`ifdef FETCH_STATIC_PREDICT_EN
        predict_case(32'h40, 32'h0200006f, 32'h60);
        predict_case(32'h80, 32'hfe000ce3, 32'h78);
`else
        predict_case(32'h40, 32'h0200006f, 32'h44);
        predict_case(32'h80, 32'hfe000ce3, 32'h84);
`endif
        predict_case(32'h80, 32'h00000863, 32'h84);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
